ps2_keyboard_rx: RTL and testbench

- PS/2 keyboard receive front-end that feeds the AXI4-Lite keyboard subordinate's register file.
- Synchronises and de-glitches the PS/2 clock and data lines, then deframes 11-bit device-to-host frames with odd-parity and framing checks.
- Folds E0 (extended) and F0 (break) prefix bytes into flags on the following scancode.
- Queues decoded key events in a small first-word-fall-through (FWFT) FIFO that the subordinate pops when software reads its data register.

---
 rtl/ps2_kbd_pkg.sv | 20 ++
 rtl/ps2_input_filter.sv | 60 ++++++
 rtl/ps2_keyboard_rx.sv | 174 +++++++++++++++++
 tb/tb_ps2_keyboard_rx.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/ps2_kbd_pkg.sv
// Shared types and constants for the PS/2 keyboard receive path.
package ps2_kbd_pkg;

    // One decoded key event as stored in the event FIFO.
    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } kbd_event_t;

    localparam logic [7:0] PS2_EXT_PREFIX = 8'hE0;
    localparam logic [7:0] PS2_BRK_PREFIX = 8'hF0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        CHECK = 2'd2
    } rx_state_t;

endpackage

// File: rtl/ps2_input_filter.sv
// Synchronises the raw PS/2 pins, de-glitches the clock line and emits a
// one-cycle strobe on each filtered falling edge of the PS/2 clock.
module ps2_input_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic ACLK,
    input  logic ARESETN,
    input  logic ps2_clk_i,
    input  logic ps2_data_i,
    output logic fall,
    output logic data
);

    localparam int CNT_W = $clog2(FILTER_LEN + 1);

    logic             clk_meta, clk_sync;
    logic             data_meta, data_sync;
    logic             clk_filt;
    logic [CNT_W-1:0] flt_cnt;

    // Two-flop synchronisers; the idle bus level is high, so reset to 1.
    // NOTE: sequential state always uses non-blocking assignments so every
    // flop samples the pre-edge value of its neighbours.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            clk_meta  <= 1'b1;
            clk_sync  <= 1'b1;
            data_meta <= 1'b1;
            data_sync <= 1'b1;
        end else begin
            clk_meta  <= ps2_clk_i;
            clk_sync  <= clk_meta;
            data_meta <= ps2_data_i;
            data_sync <= data_meta;
        end
    end

    // Filtered clock flips only after FILTER_LEN consecutive differing samples.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            clk_filt <= 1'b1;
            flt_cnt  <= '0;
            fall     <= 1'b0;
        end else begin
            fall <= 1'b0;
            if (clk_sync == clk_filt) begin
                flt_cnt <= '0;
            end else if (flt_cnt == CNT_W'(FILTER_LEN - 1)) begin
                clk_filt <= clk_sync;
                flt_cnt  <= '0;
                fall     <= clk_filt;
            end else begin
                flt_cnt <= flt_cnt + 1'b1;
            end
        end
    end

    assign data = data_sync;

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: frame deserialiser, prefix folding decoder and a
// first-word-fall-through event FIFO with sticky error flags.
module ps2_keyboard_rx
    import ps2_kbd_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 20000,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                          ACLK,
    input  logic                          ARESETN,
    input  logic                          ps2_clk_i,
    input  logic                          ps2_data_i,
    input  logic                          rd_en,
    output logic [9:0]                    dout,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          overflow,
    output logic                          parity_err,
    output logic                          frame_err,
    input  logic                          clr_err
);

    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [AW:0]      FULL_CNT = (AW + 1)'(FIFO_DEPTH);

    logic fall, data;

    ps2_input_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
        .ACLK       (ACLK),
        .ARESETN    (ARESETN),
        .ps2_clk_i  (ps2_clk_i),
        .ps2_data_i (ps2_data_i),
        .fall       (fall),
        .data       (data)
    );

    rx_state_t        state;
    logic [3:0]       bit_cnt;
    logic [9:0]       shift;
    logic [TMO_W-1:0] tmo_cnt;
    logic             pend_ext, pend_brk;

    logic             stop_ok, par_ok, is_prefix;
    logic             frame_set, parity_set, push;
    kbd_event_t       new_ev;

    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      occ;
    logic             full, do_pop, do_push, overflow_set;
    kbd_event_t       mem [FIFO_DEPTH];

    // Frame checks on the completed shift register: data[7:0], parity, stop.
    assign stop_ok   = shift[9];
    assign par_ok    = ^shift[8:0];
    assign is_prefix = (shift[7:0] == PS2_EXT_PREFIX) || (shift[7:0] == PS2_BRK_PREFIX);

    // Error strobes and event push derived from the current FSM state.
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        frame_set  = 1'b0;
        parity_set = 1'b0;
        push       = 1'b0;
        new_ev     = '{ext: pend_ext, brk: pend_brk, code: shift[7:0]};
        case (state)
            IDLE:  frame_set = fall & data;
            RECV:  frame_set = !fall && (tmo_cnt == TMO_LAST);
            CHECK: begin
                frame_set  = !stop_ok;
                parity_set = !par_ok;
                push       = stop_ok && par_ok && !is_prefix;
            end
            default: ;
        endcase
    end

    // Frame deserialiser FSM with inter-edge timeout and prefix tracking.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            shift    <= '0;
            tmo_cnt  <= '0;
            pend_ext <= 1'b0;
            pend_brk <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    tmo_cnt <= '0;
                    if (fall && !data) begin
                        state   <= RECV;
                        bit_cnt <= '0;
                    end
                end
                RECV: begin
                    if (fall) begin
                        shift   <= {data, shift[9:1]};
                        tmo_cnt <= '0;
                        if (bit_cnt == 4'd9) state <= CHECK;
                        else                 bit_cnt <= bit_cnt + 4'd1;
                    end else if (tmo_cnt == TMO_LAST) begin
                        state <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                CHECK: begin
                    state <= IDLE;
                    if (stop_ok && par_ok) begin
                        if (shift[7:0] == PS2_EXT_PREFIX) begin
                            pend_ext <= 1'b1;
                        end else if (shift[7:0] == PS2_BRK_PREFIX) begin
                            pend_brk <= 1'b1;
                        end else begin
                            pend_ext <= 1'b0;
                            pend_brk <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign full         = (occ == FULL_CNT);
    assign do_pop       = rd_en && (occ != '0);
    assign do_push      = push && (!full || do_pop);
    assign overflow_set = push && full && !do_pop;

    // FIFO pointers and occupancy; power-of-2 depth makes pointers wrap.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      occ <= occ + 1'b1;
            else if (do_pop && !do_push) occ <= occ - 1'b1;
        end
    end

    // Event storage.
    // NOTE: the array has no reset; entries are only visible once written,
    // and dout is forced to zero while empty.
    always_ff @(posedge ACLK) begin
        if (do_push) mem[wr_ptr] <= new_ev;
    end

    // Sticky error flags; a new error in the clear cycle wins.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            overflow   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            if (overflow_set)    overflow   <= 1'b1;
            else if (clr_err)    overflow   <= 1'b0;
            if (parity_set)      parity_err <= 1'b1;
            else if (clr_err)    parity_err <= 1'b0;
            if (frame_set)       frame_err  <= 1'b1;
            else if (clr_err)    frame_err  <= 1'b0;
        end
    end

    assign empty = (occ == '0);
    assign count = occ;
    assign dout  = empty ? 10'd0 : mem[rd_ptr];

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Directed bench for ps2_keyboard_rx using a shortened bit period.
module tb_ps2_keyboard_rx;

    localparam int FILTER_LEN = 8;
    localparam int TMO        = 300;
    localparam int DEPTH      = 4;
    localparam int HALF       = 20;   // ACLK cycles per PS/2 clock half period

    logic       ACLK = 1'b0;
    logic       ARESETN = 1'b0;
    logic       ps2_clk_i = 1'b1;
    logic       ps2_data_i = 1'b1;
    logic       rd_en = 1'b0;
    logic       clr_err = 1'b0;
    logic [9:0] dout;
    logic       empty;
    logic [2:0] count;
    logic       overflow, parity_err, frame_err;

    int vectors = 0;
    int miscompares = 0;

    ps2_keyboard_rx #(
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TMO),
        .FIFO_DEPTH     (DEPTH)
    ) dut (
        .ACLK       (ACLK),
        .ARESETN    (ARESETN),
        .ps2_clk_i  (ps2_clk_i),
        .ps2_data_i (ps2_data_i),
        .rd_en      (rd_en),
        .dout       (dout),
        .empty      (empty),
        .count      (count),
        .overflow   (overflow),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .clr_err    (clr_err)
    );

    always #5 ACLK = ~ACLK;

    // Send the first nbits of a frame; bits change while the PS/2 clock is high.
    task automatic send_frame(input logic [7:0] b, input logic flip_par,
                              input logic stop_bit, input int nbits);
        logic [10:0] bits;
        bits = {stop_bit, (~^b) ^ flip_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            @(negedge ACLK) ps2_data_i = bits[i];
            repeat (HALF) @(negedge ACLK);
            ps2_clk_i = 1'b0;
            repeat (HALF) @(negedge ACLK);
            ps2_clk_i = 1'b1;
        end
        repeat (HALF) @(negedge ACLK);
        ps2_data_i = 1'b1;
        repeat (2 * HALF) @(negedge ACLK);
    endtask

    task automatic pop();
        @(negedge ACLK) rd_en = 1'b1;
        @(negedge ACLK) rd_en = 1'b0;
    endtask

    task automatic clear_errors();
        @(negedge ACLK) clr_err = 1'b1;
        @(negedge ACLK) clr_err = 1'b0;
    endtask

    task automatic test_reset();
        vectors++; if (dout !== 10'h000) begin miscompares++; $display("FAIL reset_dout: got %h expected 000", dout); end
        vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL reset_empty: got %b expected 1", empty); end
        vectors++; if (count !== 3'd0) begin miscompares++; $display("FAIL reset_count: got %0d expected 0", count); end
        vectors++; if ({overflow, parity_err, frame_err} !== 3'b000) begin miscompares++; $display("FAIL reset_flags: got %b expected 000", {overflow, parity_err, frame_err}); end
    endtask

    task automatic test_make_code();
        send_frame(8'h1C, 1'b0, 1'b1, 11);
        vectors++; if (empty !== 1'b0) begin miscompares++; $display("FAIL make_empty: got %b expected 0", empty); end
        vectors++; if (dout !== 10'h01C) begin miscompares++; $display("FAIL make_dout: got %h expected 01c", dout); end
        vectors++; if (count !== 3'd1) begin miscompares++; $display("FAIL make_count: got %0d expected 1", count); end
        pop();
        vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL make_pop_empty: got %b expected 1", empty); end
        vectors++; if (dout !== 10'h000) begin miscompares++; $display("FAIL make_pop_dout: got %h expected 000", dout); end
    endtask

    task automatic test_ext_break();
        send_frame(8'hE0, 1'b0, 1'b1, 11);
        vectors++; if (count !== 3'd0) begin miscompares++; $display("FAIL ext_prefix_count: got %0d expected 0", count); end
        send_frame(8'hF0, 1'b0, 1'b1, 11);
        send_frame(8'h75, 1'b0, 1'b1, 11);
        vectors++; if (count !== 3'd1) begin miscompares++; $display("FAIL extbrk_count: got %0d expected 1", count); end
        vectors++; if (dout !== 10'h375) begin miscompares++; $display("FAIL extbrk_dout: got %h expected 375", dout); end
        pop();
        // Flags must have been cleared by the pushed event.
        send_frame(8'h1C, 1'b0, 1'b1, 11);
        vectors++; if (dout !== 10'h01C) begin miscompares++; $display("FAIL prefix_cleared_dout: got %h expected 01c", dout); end
        pop();
    endtask

    task automatic test_errors();
        send_frame(8'h1C, 1'b1, 1'b1, 11);
        vectors++; if (parity_err !== 1'b1) begin miscompares++; $display("FAIL parity_flag: got %b expected 1", parity_err); end
        vectors++; if (frame_err !== 1'b0) begin miscompares++; $display("FAIL parity_no_frame: got %b expected 0", frame_err); end
        vectors++; if (count !== 3'd0) begin miscompares++; $display("FAIL parity_count: got %0d expected 0", count); end
        clear_errors();
        vectors++; if (parity_err !== 1'b0) begin miscompares++; $display("FAIL parity_clr: got %b expected 0", parity_err); end
        send_frame(8'h1C, 1'b0, 1'b0, 11);
        vectors++; if (frame_err !== 1'b1) begin miscompares++; $display("FAIL stop_flag: got %b expected 1", frame_err); end
        vectors++; if (count !== 3'd0) begin miscompares++; $display("FAIL stop_count: got %0d expected 0", count); end
        clear_errors();
        vectors++; if ({overflow, parity_err, frame_err} !== 3'b000) begin miscompares++; $display("FAIL clr_flags: got %b expected 000", {overflow, parity_err, frame_err}); end
    endtask

    task automatic test_overflow_wrap();
        logic [9:0] exp;
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b0, 1'b1, 11);
        vectors++; if (count !== 3'd4) begin miscompares++; $display("FAIL ovf_count: got %0d expected 4", count); end
        vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_flag: got %b expected 1", overflow); end
        for (int i = 1; i <= 4; i++) begin
            exp = 10'(i);
            vectors++; if (dout !== exp) begin miscompares++; $display("FAIL ovf_read%0d: got %h expected %h", i, dout, exp); end
            pop();
        end
        vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL ovf_drained: got %b expected 1", empty); end
        send_frame(8'h06, 1'b0, 1'b1, 11);
        vectors++; if (dout !== 10'h006) begin miscompares++; $display("FAIL wrap_dout: got %h expected 006", dout); end
        pop();
        clear_errors();
        vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL ovf_clr: got %b expected 0", overflow); end
    endtask

    task automatic test_timeout();
        send_frame(8'h5A, 1'b0, 1'b1, 4);
        vectors++; if (frame_err !== 1'b0) begin miscompares++; $display("FAIL tmo_early: got %b expected 0", frame_err); end
        repeat (TMO + 50) @(negedge ACLK);
        vectors++; if (frame_err !== 1'b1) begin miscompares++; $display("FAIL tmo_flag: got %b expected 1", frame_err); end
        vectors++; if (count !== 3'd0) begin miscompares++; $display("FAIL tmo_count: got %0d expected 0", count); end
        clear_errors();
        send_frame(8'h1C, 1'b0, 1'b1, 11);
        vectors++; if (dout !== 10'h01C) begin miscompares++; $display("FAIL tmo_recover_dout: got %h expected 01c", dout); end
        vectors++; if (frame_err !== 1'b0) begin miscompares++; $display("FAIL tmo_recover_err: got %b expected 0", frame_err); end
        pop();
    endtask

    task automatic test_mid_reset();
        send_frame(8'h2B, 1'b0, 1'b1, 11);
        send_frame(8'h1C, 1'b0, 1'b1, 5);
        @(negedge ACLK) ARESETN = 1'b0;
        #1;
        vectors++; if ({dout, empty, count} !== {10'h000, 1'b1, 3'd0}) begin miscompares++; $display("FAIL midrst_outputs: got %h/%b/%0d expected 000/1/0", dout, empty, count); end
        repeat (3) @(negedge ACLK);
        ARESETN = 1'b1;
        send_frame(8'h1C, 1'b0, 1'b1, 11);
        vectors++; if ({dout, count} !== {10'h01C, 3'd1}) begin miscompares++; $display("FAIL midrst_after: got %h/%0d expected 01c/1", dout, count); end
        vectors++; if (frame_err !== 1'b0) begin miscompares++; $display("FAIL midrst_err: got %b expected 0", frame_err); end
        pop();
    endtask

    task automatic test_glitch();
        @(negedge ACLK) ps2_clk_i = 1'b0;
        repeat (3) @(negedge ACLK);
        ps2_clk_i = 1'b1;
        repeat (40) @(negedge ACLK);
        vectors++; if ({frame_err, parity_err} !== 2'b00) begin miscompares++; $display("FAIL glitch_err: got %b expected 00", {frame_err, parity_err}); end
        vectors++; if (count !== 3'd0) begin miscompares++; $display("FAIL glitch_count: got %0d expected 0", count); end
        send_frame(8'h3A, 1'b0, 1'b1, 11);
        vectors++; if (dout !== 10'h03A) begin miscompares++; $display("FAIL glitch_after: got %h expected 03a", dout); end
        pop();
    endtask

    initial begin
        repeat (4) @(negedge ACLK);
        ARESETN = 1'b1;
        repeat (4) @(negedge ACLK);
        test_reset();
        test_make_code();
        test_ext_break();
        test_errors();
        test_overflow_wrap();
        test_timeout();
        test_glitch();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
